// File: rtl/mux_stim_gen_pkg.sv
// rtl/mux_stim_gen_pkg.sv - shared types and constants for the mux stimulus generator
package mux_stim_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Right-shifting Galois mask for x^64+x^63+x^61+x^60+1
    localparam logic [63:0] LFSR_POLY    = 64'hD800_0000_0000_0000;
    localparam logic [63:0] DEFAULT_SEED = 64'hACE1_2468_0F0F_1357;
    localparam logic [31:0] MISR_POLY    = 32'h04C1_1DB7;

    localparam int SEL2_W  = 1;
    localparam int SEL8_W  = 3;
    localparam int SEL16_W = 4;
    localparam int SEL32_W = 5;
    localparam int SEL64_W = 6;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        lfsr_next = {1'b0, s[63:1]} ^ (s[0] ? LFSR_POLY : 64'h0);
    endfunction

endpackage

// File: rtl/mux_stim_gen_lfsr64.sv
// rtl/mux_stim_gen_lfsr64.sv - 64-bit Galois LFSR with seed load and advance
module mux_stim_lfsr64
    import mux_stim_gen_pkg::*;
#(
    parameter logic [63:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_val,
    input  logic        advance,
    output logic [63:0] state
);

    logic [63:0] state_q;
    logic [63:0] state_d;

    // Load wins over advance; a zero seed would lock the LFSR, so it maps to SEED
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val == 64'h0) ? SEED : load_val;
        end else if (advance) begin
            state_d = lfsr_next(state_q);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/mux_stim_gen.sv
// rtl/mux_stim_gen.sv - registered LFSR/sweep stimulus generator for mux characterization (optional MISR: MUX_STIM_MISR_EN)
module mux_stim_gen
    import mux_stim_gen_pkg::*;
#(
    parameter int          CNT_W = 16,
    parameter logic [63:0] SEED  = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_vec,
    input  logic               sweep_mode,
    input  logic               seed_load,
    input  logic [63:0]        seed,
    output logic               busy,
    output logic               done,
    output logic               vec_valid,
    output logic [1:0]         in2,
    output logic [7:0]         in8,
    output logic [15:0]        in16,
    output logic [31:0]        in32,
    output logic [63:0]        in64,
    output logic [SEL2_W-1:0]  sel2,
    output logic [SEL8_W-1:0]  sel8,
    output logic [SEL16_W-1:0] sel16,
    output logic [SEL32_W-1:0] sel32,
    output logic [SEL64_W-1:0] sel64
`ifdef MUX_STIM_MISR_EN
    ,
    input  logic [4:0]         mux_out,
    output logic [31:0]        signature
`endif
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   numv_q, numv_d;
    logic               sweep_q, sweep_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               vec_valid_q, vec_valid_d;
    logic [1:0]         in2_q, in2_d;
    logic [7:0]         in8_q, in8_d;
    logic [15:0]        in16_q, in16_d;
    logic [31:0]        in32_q, in32_d;
    logic [63:0]        in64_q, in64_d;
    logic [SEL2_W-1:0]  sel2_q, sel2_d;
    logic [SEL8_W-1:0]  sel8_q, sel8_d;
    logic [SEL16_W-1:0] sel16_q, sel16_d;
    logic [SEL32_W-1:0] sel32_q, sel32_d;
    logic [SEL64_W-1:0] sel64_q, sel64_d;

    logic               lfsr_load;
    logic               lfsr_adv;
    logic [63:0]        lfsr;
    logic               load_vec;
    logic               sweep_eff;
    logic               start_acc;
    logic [CNT_W-1:0]   vec_cnt;

    mux_stim_lfsr64 #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (seed),
        .advance  (lfsr_adv),
        .state    (lfsr)
    );

    // FSM next state, vector sequencing and output-register loads
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        numv_d      = numv_q;
        sweep_d     = sweep_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        vec_valid_d = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;
        load_vec    = 1'b0;
        start_acc   = 1'b0;
        sweep_eff   = sweep_q;
        vec_cnt     = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (seed_load) begin
                    lfsr_load = 1'b1;
                end else if (start) begin
                    start_acc = 1'b1;
                    numv_d    = num_vec;
                    sweep_d   = sweep_mode;
                    if (num_vec != '0) begin
                        state_d     = ST_RUN;
                        load_vec    = 1'b1;
                        lfsr_adv    = 1'b1;
                        sweep_eff   = sweep_mode;
                        vec_cnt     = '0;
                        cnt_d       = {{(CNT_W-1){1'b0}}, 1'b1};
                        busy_d      = 1'b1;
                        vec_valid_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q < numv_q) begin
                    load_vec    = 1'b1;
                    lfsr_adv    = 1'b1;
                    cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    busy_d      = 1'b1;
                    vec_valid_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in2_d   = in2_q;
        in8_d   = in8_q;
        in16_d  = in16_q;
        in32_d  = in32_q;
        in64_d  = in64_q;
        sel2_d  = sel2_q;
        sel8_d  = sel8_q;
        sel16_d = sel16_q;
        sel32_d = sel32_q;
        sel64_d = sel64_q;
        if (load_vec) begin
            in64_d = lfsr;
            in32_d = lfsr[31:0] ^ lfsr[63:32];
            in16_d = lfsr[15:0] ^ lfsr[47:32];
            in8_d  = lfsr[7:0]  ^ lfsr[39:32];
            in2_d  = lfsr[1:0]  ^ lfsr[33:32];
            if (sweep_eff) begin
                sel64_d = vec_cnt[5:0];
                sel32_d = vec_cnt[4:0];
                sel16_d = vec_cnt[3:0];
                sel8_d  = vec_cnt[2:0];
                sel2_d  = vec_cnt[0];
            end else begin
                sel64_d = lfsr[63:58];
                sel32_d = lfsr[57:53];
                sel16_d = lfsr[52:49];
                sel8_d  = lfsr[48:46];
                sel2_d  = lfsr[45];
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            numv_q      <= '0;
            sweep_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vec_valid_q <= 1'b0;
            in2_q       <= '0;
            in8_q       <= '0;
            in16_q      <= '0;
            in32_q      <= '0;
            in64_q      <= '0;
            sel2_q      <= '0;
            sel8_q      <= '0;
            sel16_q     <= '0;
            sel32_q     <= '0;
            sel64_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            numv_q      <= numv_d;
            sweep_q     <= sweep_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vec_valid_q <= vec_valid_d;
            in2_q       <= in2_d;
            in8_q       <= in8_d;
            in16_q      <= in16_d;
            in32_q      <= in32_d;
            in64_q      <= in64_d;
            sel2_q      <= sel2_d;
            sel8_q      <= sel8_d;
            sel16_q     <= sel16_d;
            sel32_q     <= sel32_d;
            sel64_q     <= sel64_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_valid = vec_valid_q;
    assign in2       = in2_q;
    assign in8       = in8_q;
    assign in16      = in16_q;
    assign in32      = in32_q;
    assign in64      = in64_q;
    assign sel2      = sel2_q;
    assign sel8      = sel8_q;
    assign sel16     = sel16_q;
    assign sel32     = sel32_q;
    assign sel64     = sel64_q;

`ifdef MUX_STIM_MISR_EN
    logic [31:0] sig_q, sig_d;

    // Signature compacts the mux outputs seen during each valid vector cycle
    always_comb begin
        sig_d = sig_q;
        if (start_acc) begin
            sig_d = '0;
        end else if (vec_valid_q) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ {27'b0, mux_out};
        end
    end

    // Signature register
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`endif

endmodule

// File: tb/tb_mux_stim_gen.sv
// tb/tb_mux_stim_gen.sv - directed self-checking bench for mux_stim_gen
module tb_mux_stim_gen;

    localparam logic [63:0] G_SEED = 64'hACE1_2468_0F0F_1357;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_vec;
    logic        sweep_mode;
    logic        seed_load;
    logic [63:0] seed;
    logic        busy, done, vec_valid;
    logic [1:0]  in2;
    logic [7:0]  in8;
    logic [15:0] in16;
    logic [31:0] in32;
    logic [63:0] in64;
    logic        sel2;
    logic [2:0]  sel8;
    logic [3:0]  sel16;
    logic [4:0]  sel32;
    logic [5:0]  sel64;
`ifdef MUX_STIM_MISR_EN
    logic [4:0]  mux_out;
    logic [31:0] signature;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] m;

    mux_stim_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_vec    (num_vec),
        .sweep_mode (sweep_mode),
        .seed_load  (seed_load),
        .seed       (seed),
        .busy       (busy),
        .done       (done),
        .vec_valid  (vec_valid),
        .in2        (in2),
        .in8        (in8),
        .in16       (in16),
        .in32       (in32),
        .in64       (in64),
        .sel2       (sel2),
        .sel8       (sel8),
        .sel16      (sel16),
        .sel32      (sel32),
        .sel64      (sel64)
`ifdef MUX_STIM_MISR_EN
        ,
        .mux_out    (mux_out),
        .signature  (signature)
`endif
    );

    always #5 clk = ~clk;

    // Galois step with feedback taps at bits 63, 62, 60, 59
    function automatic logic [63:0] galois(input logic [63:0] s);
        logic [63:0] r;
        logic        fb;
        fb    = s[0];
        r     = s >> 1;
        r[63] = r[63] ^ fb;
        r[62] = r[62] ^ fb;
        r[60] = r[60] ^ fb;
        r[59] = r[59] ^ fb;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_vec = '0; sweep_mode = 1'b0;
        seed_load = 1'b0; seed = '0;
`ifdef MUX_STIM_MISR_EN
        mux_out = '0;
`endif
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", vec_valid, 0);
        chk("rst_in64", in64, 0);
        chk("rst_sel64", sel64, 0);
        rst = 1'b0;
        tick();

        // LFSR run of 4 vectors
        m = G_SEED;
        start = 1'b1; num_vec = 16'd4; sweep_mode = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("r1_valid", vec_valid, 1);
            chk("r1_busy", busy, 1);
            chk("r1_done", done, 0);
            chk("r1_in64", in64, m);
            chk("r1_in32", in32, m[31:0] ^ m[63:32]);
            chk("r1_in16", in16, m[15:0] ^ m[47:32]);
            chk("r1_in8", in8, m[7:0] ^ m[39:32]);
            chk("r1_in2", in2, m[1:0] ^ m[33:32]);
            chk("r1_sel64", sel64, m[63:58]);
            chk("r1_sel32", sel32, m[57:53]);
            chk("r1_sel16", sel16, m[52:49]);
            chk("r1_sel8", sel8, m[48:46]);
            chk("r1_sel2", sel2, m[45]);
            if (i < 3) m = galois(m);
            tick();
        end
        chk("r1_end_valid", vec_valid, 0);
        chk("r1_end_busy", busy, 0);
        chk("r1_end_done", done, 1);
        chk("r1_hold_in64", in64, m);
        m = galois(m);
        tick();
        chk("r1_done_once", done, 0);

        // Sweep run of 64 vectors
        start = 1'b1; num_vec = 16'd64; sweep_mode = 1'b1;
        tick();
        start = 1'b0; sweep_mode = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("sw_valid", vec_valid, 1);
            chk("sw_sel64", sel64, 64'(i));
            chk("sw_sel8", sel8, 64'(i % 8));
            chk("sw_sel2", sel2, 64'(i % 2));
            chk("sw_in64", in64, m);
            m = galois(m);
            tick();
        end
        chk("sw_end_valid", vec_valid, 0);
        chk("sw_end_done", done, 1);
        tick();

        // Zero-length run
        start = 1'b1; num_vec = 16'd0;
        tick();
        start = 1'b0;
        chk("z_done", done, 1);
        chk("z_valid", vec_valid, 0);
        chk("z_busy", busy, 0);
        tick();
        chk("z_done_off", done, 0);
        chk("z_busy_off", busy, 0);

        // Zero seed maps to SEED
        seed_load = 1'b1; seed = 64'h0;
        tick();
        seed_load = 1'b0;
        start = 1'b1; num_vec = 16'd1;
        tick();
        start = 1'b0;
        chk("s0_in64", in64, G_SEED);
        tick();
        chk("s0_done", done, 1);
        tick();

        // Seed of one
        seed_load = 1'b1; seed = 64'h1;
        tick();
        seed_load = 1'b0;
        start = 1'b1; num_vec = 16'd2;
        tick();
        start = 1'b0;
        chk("s1_in64", in64, 64'h1);
        tick();
        chk("s1_in64_b", in64, galois(64'h1));
        tick();
        chk("s1_done", done, 1);
        tick();

        // seed_load beats start in the same cycle
        seed_load = 1'b1; seed = 64'h5; start = 1'b1; num_vec = 16'd3;
        tick();
        seed_load = 1'b0; start = 1'b0;
        chk("sl_busy", busy, 0);
        chk("sl_valid", vec_valid, 0);
        chk("sl_done", done, 0);
        tick();
        chk("sl_busy2", busy, 0);
        chk("sl_done2", done, 0);
        start = 1'b1; num_vec = 16'd1;
        tick();
        start = 1'b0;
        chk("sl_in64", in64, 64'h5);
        tick(); tick();

        // Extra start mid-run ignored, then reset aborts the run
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m = G_SEED;
        start = 1'b1; num_vec = 16'd10; sweep_mode = 1'b0;
        tick();
        num_vec = 16'd2; sweep_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("ab_valid", vec_valid, 1);
            chk("ab_busy", busy, 1);
            chk("ab_in64", in64, m);
            chk("ab_sel64", sel64, m[63:58]);
            m = galois(m);
            tick();
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ab_rst_valid", vec_valid, 0);
        chk("ab_rst_busy", busy, 0);
        chk("ab_rst_done", done, 0);
        chk("ab_rst_in64", in64, 0);
        chk("ab_rst_in32", in32, 0);
        chk("ab_rst_sel64", sel64, 0);
        tick();
        chk("ab_no_done", done, 0);
        m = G_SEED;
        start = 1'b1; num_vec = 16'd10; sweep_mode = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("rr_in64", in64, m);
            chk("rr_valid", vec_valid, 1);
            m = galois(m);
            tick();
        end
        chk("rr_done", done, 1);
        chk("rr_valid_end", vec_valid, 0);
        tick();

`ifdef MUX_STIM_MISR_EN
        // MISR: 0 -> 0x15 -> 0x3F -> 0x6B with mux_out = 5'b10101
        mux_out = 5'b10101;
        start = 1'b1; num_vec = 16'd3;
        tick();
        start = 1'b0;
        chk("misr_clear", signature, 0);
        tick();
        chk("misr_1", signature, 64'h15);
        tick();
        chk("misr_2", signature, 64'h3F);
        tick();
        chk("misr_3", signature, 64'h6B);
        chk("misr_done", done, 1);
        tick(); tick();
        chk("misr_hold", signature, 64'h6B);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
